// File: rtl/fifo_packer.sv
// Packs PACK_FACTOR consecutive FIFO words into one wide output word, with flush of partial words.
// Optional feature macro: PACKER_PARITY_EN adds the registered even-parity output out_parity.
module fifo_packer #(
  parameter int DATA_WIDTH  = 8,
  parameter int PACK_FACTOR = 4,
  parameter int CNT_WIDTH   = 3
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              fifo_empty,
  input  logic [DATA_WIDTH-1:0]             fifo_data,
  output logic                              fifo_rd,
  input  logic                              flush,
  output logic [DATA_WIDTH*PACK_FACTOR-1:0] out_data,
  output logic [CNT_WIDTH-1:0]              out_count,
  output logic                              out_valid,
  input  logic                              out_ready,
`ifdef PACKER_PARITY_EN
  output logic                              out_parity,
`endif
  output logic                              dbg_state,
  output logic [CNT_WIDTH-1:0]              dbg_count
);

  localparam int OUT_W = DATA_WIDTH * PACK_FACTOR;
  localparam logic [CNT_WIDTH:0] PF_EXT = (CNT_WIDTH+1)'(PACK_FACTOR);

  typedef enum logic {S_FILL = 1'b0, S_OUT = 1'b1} state_t;

  state_t                 state, state_next;
  logic [CNT_WIDTH-1:0]   count;
  logic                   pend;
  logic                   flush_hold;
  logic [OUT_W-1:0]       lanes, lanes_next;
  logic [CNT_WIDTH:0]     inflight;
  logic [CNT_WIDTH-1:0]   count_next;
  logic                   fill_done;
  logic                   handshake;

  // Lanes already captured plus the read whose data arrives this cycle.
  assign inflight   = {1'b0, count} + {{CNT_WIDTH{1'b0}}, pend};
  assign count_next = inflight[CNT_WIDTH-1:0];
  assign fill_done  = (inflight == PF_EXT) | (flush_hold & ~pend);
  // Output handshake: a word transfers on a cycle where out_valid and out_ready are both high;
  // out_data/out_count/out_parity stay constant while out_valid is high and out_ready is low.
  assign handshake  = (state == S_OUT) & out_ready;

  assign dbg_state = state;
  assign dbg_count = count;

  always_comb begin
    lanes_next = lanes;
    if (pend) begin
      for (int i = 0; i < PACK_FACTOR; i++) begin
        if (count == CNT_WIDTH'(i)) lanes_next[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_FILL;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FILL:  if (fill_done) state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_FILL;
      default: state_next = S_FILL;
    endcase
  end

  always_comb begin
    fifo_rd   = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_FILL:  fifo_rd = ~reset & en & ~fifo_empty & ~flush_hold & (inflight < PF_EXT);
      S_OUT:   out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      pend       <= 1'b0;
      flush_hold <= 1'b0;
      lanes      <= '0;
      out_data   <= '0;
      out_count  <= '0;
    end else begin
      case (state)
        S_FILL: begin
          pend  <= fifo_rd;
          count <= count_next;
          lanes <= lanes_next;
          // An empty packer ignores flush so no zero-lane word is ever produced.
          if (flush && (inflight != '0)) flush_hold <= 1'b1;
          if (fill_done) begin
            out_data  <= lanes_next;
            out_count <= count_next;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            count      <= '0;
            flush_hold <= 1'b0;
            lanes      <= '0;
            out_data   <= '0;
            out_count  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PACKER_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset)                               out_parity <= 1'b0;
    else if ((state == S_FILL) && fill_done) out_parity <= ^lanes_next;
    else if (handshake)                      out_parity <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_fifo_packer.sv
// Bench for fifo_packer: FIFO model, byte-stream scoreboard, directed scenarios and random traffic.
module tb_fifo_packer;
  localparam int DW = 8;
  localparam int PF = 4;
  localparam int CW = 3;
  localparam int OW = DW * PF;

  logic          clk = 1'b0;
  logic          reset, en, fifo_empty, flush, out_ready;
  logic [DW-1:0] fifo_data;
  logic          fifo_rd, out_valid;
  logic [OW-1:0] out_data;
  logic [CW-1:0] out_count;
  logic          dbg_state;
  logic [CW-1:0] dbg_count;
`ifdef PACKER_PARITY_EN
  logic          out_parity;
  logic          s_parity;
`endif

  always #5 clk = ~clk;

  fifo_packer #(.DATA_WIDTH(DW), .PACK_FACTOR(PF), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd(fifo_rd), .flush(flush), .out_data(out_data), .out_count(out_count),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef PACKER_PARITY_EN
    .out_parity(out_parity),
`endif
    .dbg_state(dbg_state), .dbg_count(dbg_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int words = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  bit            armed, stalled, hs;
  logic [OW-1:0] held_data;
  logic [CW-1:0] held_cnt;

  logic          s_reset, s_rd, s_empty, s_valid, s_ready, s_flush, s_dbg_state;
  logic [OW-1:0] s_data;
  logic [CW-1:0] s_count, s_dbg_count;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    if (fifo_q.size() < 8) begin
      fifo_q.push_back(b);
      fifo_empty = 1'b0;
    end
  endtask

  // A word holds exactly the bytes popped from the FIFO since the previous handshake.
  task automatic score();
    logic [OW-1:0] exp_w;
    exp_w = '0;
    foreach (exp_q[i]) if (i < PF) exp_w[i*DW +: DW] = exp_q[i];
    chk("word_data", out_data, exp_w);
    chk("word_cnt", 64'(out_count), 64'(exp_q.size()));
    chk("cnt_range", 64'((out_count >= 1) && (out_count <= CW'(PF))), 1);
    if (!armed) chk("word_full", 64'(out_count), 64'(PF));
`ifdef PACKER_PARITY_EN
    chk("parity", 64'(out_parity), 64'(^exp_w));
`endif
    words++;
    hs = 1'b1;
  endtask

  task automatic monitor();
    s_reset = reset; s_rd = fifo_rd; s_empty = fifo_empty; s_valid = out_valid;
    s_ready = out_ready; s_flush = flush; s_data = out_data; s_count = out_count;
    s_dbg_state = dbg_state; s_dbg_count = dbg_count;
`ifdef PACKER_PARITY_EN
    s_parity = out_parity;
`endif
    if (reset) begin
      chk("rd_in_reset", 64'(fifo_rd), 0);
    end else begin
      chk("rd_empty", 64'(fifo_rd & fifo_empty), 0);
      chk("rd_in_out", 64'(fifo_rd & out_valid), 0);
      chk("rd_en_low", 64'(fifo_rd & ~en), 0);
      if (stalled) begin
        chk("stall_valid", 64'(out_valid), 1);
        chk("stall_data", out_data, held_data);
        chk("stall_cnt", 64'(out_count), 64'(held_cnt));
      end
      if (out_valid && out_ready) score();
    end
  endtask

  task automatic edge_update();
    if (s_reset) begin
      fifo_q.delete();
      exp_q.delete();
      armed = 1'b0;
      stalled = 1'b0;
      fifo_empty = 1'b1;
    end else begin
      if (hs) begin
        exp_q.delete();
        armed = 1'b0;
      end
      if (s_flush && (exp_q.size() > 0)) armed = 1'b1;
      if (s_rd && !s_empty && (fifo_q.size() > 0)) begin
        fifo_data = fifo_q.pop_front();
        exp_q.push_back(fifo_data);
        chk("overread", 64'(exp_q.size() > PF), 0);
      end
      stalled   = s_valid & ~s_ready;
      held_data = s_data;
      held_cnt  = s_count;
      fifo_empty = (fifo_q.size() == 0);
    end
    hs = 1'b0;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    edge_update();
  endtask

  task automatic wait_word(input string tag, input int bound,
                           output logic [OW-1:0] w, output logic [CW-1:0] c);
    bit got;
    got = 1'b0;
    w = '0;
    c = '0;
    for (int i = 0; i < bound; i++) begin
      cycle();
      if (s_valid && s_ready) begin
        w = s_data;
        c = s_count;
        got = 1'b1;
        break;
      end
    end
    if (!got) chk({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    logic [11:0]   rdh, vh;
    logic [OW-1:0] w;
    logic [CW-1:0] c;
    int            nv, nrd, n0;
    bit            seen;

    reset = 1'b1; en = 1'b0; flush = 1'b0; out_ready = 1'b0;
    fifo_empty = 1'b1; fifo_data = '0;
    armed = 1'b0; stalled = 1'b0; hs = 1'b0;
    cycle();
    cycle();
    chk("rst_valid", 64'(s_valid), 0);
    chk("rst_data", s_data, 0);
    chk("rst_count", 64'(s_count), 0);
    chk("rst_state", 64'(s_dbg_state), 0);
    chk("rst_lanes", 64'(s_dbg_count), 0);
`ifdef PACKER_PARITY_EN
    chk("rst_parity", 64'(s_parity), 0);
`endif

    // Full word back-to-back, exact timing.
    reset = 1'b0; en = 1'b1; out_ready = 1'b1;
    push(8'h24); push(8'h81); push(8'h09); push(8'h63);
    w = '0;
    for (int i = 0; i < 12; i++) begin
      cycle();
      rdh[i] = s_rd;
      vh[i]  = s_valid;
      if (s_valid) w = s_data;
    end
    chk("t1_rd", 64'(rdh), 64'h00F);
    chk("t1_valid", 64'(vh), 64'h020);
    chk("t1_word", w, 32'h63098124);

    // Stall the first of two words for 3 cycles.
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)));
    n0 = words;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = s_valid;
    end
    if (!seen) chk("t2_timeout", 0, 1);
    cycle();
    cycle();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    chk("t2_words", 64'(words - n0), 2);

    // Partial word flushed by a single-cycle pulse.
    push(8'hAA); push(8'h55);
    for (int i = 0; i < 6; i++) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    wait_word("t3", 12, w, c);
    chk("t3_word", w, 32'h000055AA);
    chk("t3_cnt", 64'(c), 2);

    // Flush with nothing captured is ignored.
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    nv = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      nv += int'(s_valid);
    end
    chk("t4_novalid", 64'(nv), 0);
    chk("t4_state", 64'(s_dbg_state), 0);
    chk("t4_lanes", 64'(s_dbg_count), 0);

    // Flush while a read is in flight keeps the in-flight byte.
    push(8'h3C);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    wait_word("t4b", 10, w, c);
    chk("t4b_word", w, 32'h0000003C);
    chk("t4b_cnt", 64'(c), 1);

    // en dropped after two reads, then restored.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    cycle();
    cycle();
    en = 1'b0;
    nrd = 0;
    nv = 0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      nrd += int'(s_rd);
      nv  += int'(s_valid);
    end
    chk("t5_nord", 64'(nrd), 0);
    chk("t5_novalid", 64'(nv), 0);
    en = 1'b1;
    wait_word("t5", 12, w, c);
    chk("t5_word", w, 32'h44332211);
    chk("t5_cnt", 64'(c), 4);

    // Reset with three lanes filled discards them.
    push(8'hA1); push(8'hB2); push(8'hC3);
    for (int i = 0; i < 6; i++) cycle();
    chk("t6_lanes_pre", 64'(s_dbg_count), 3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("t6_valid", 64'(s_valid), 0);
    chk("t6_data", s_data, 0);
    chk("t6_count", 64'(s_count), 0);
    chk("t6_lanes", 64'(s_dbg_count), 0);
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    wait_word("t6", 12, w, c);
    chk("t6_word", w, 32'h04030201);

    // Random traffic against the byte-stream scoreboard.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) push(8'($urandom_range(0, 255)));
      en        = ($urandom_range(0, 7) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    en = 1'b1; out_ready = 1'b1; flush = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    chk("drain_fifo", 64'(fifo_q.size()), 0);
    chk("drain_pack", 64'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
